// File: rtl/mul_operand_sequencer.sv
// Front-end for the repeated-addition multiplier: accepts an operand pair, serialises
// A and B onto the shared data_in bus, waits for done and returns the product.
module mul_operand_sequencer #(
    parameter int W           = 16,
    parameter int TIMEOUT     = 70000,
    parameter int CNT_W       = 17,
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         mul_start,
    output logic [W-1:0] mul_data,
    input  logic         mul_done,
    input  logic [W-1:0] mul_product,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_err,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        LOAD_A,
        LOAD_B,
        WAIT,
        OUT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [W-1:0]     a_q, a_nxt;
    logic [W-1:0]     b_q, b_nxt;
    logic [W-1:0]     res_data_nxt;
    logic             res_err_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             zero_op;
    logic             timed_out;

    assign zero_op   = (op_a == '0) || (op_b == '0);
    assign timed_out = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt      <= '0;
            res_data <= '0;
            res_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            cnt      <= cnt_nxt;
            res_data <= res_data_nxt;
            res_err  <= res_err_nxt;
        end
    end

    // op_ready is gated by rst so the upstream never sees a handshake during reset.
    always_comb begin
        state_nxt    = state;
        a_nxt        = a_q;
        b_nxt        = b_q;
        cnt_nxt      = cnt;
        res_data_nxt = res_data;
        res_err_nxt  = res_err;
        op_ready     = 1'b0;
        mul_start    = 1'b0;
        mul_data     = '0;
        res_valid    = 1'b0;
        busy         = 1'b1;

        unique case (state)
            IDLE: begin
                busy     = 1'b0;
                op_ready = !rst;
                if (op_valid) begin
                    a_nxt = op_a;
                    b_nxt = op_b;
                    if (BYPASS_ZERO && zero_op) begin
                        res_data_nxt = '0;
                        res_err_nxt  = 1'b0;
                        state_nxt    = OUT;
                    end else begin
                        state_nxt = START;
                    end
                end
            end
            START: begin
                mul_start = 1'b1;
                state_nxt = LOAD_A;
            end
            LOAD_A: begin
                mul_data  = a_q;
                state_nxt = LOAD_B;
            end
            LOAD_B: begin
                mul_data  = b_q;
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                cnt_nxt = cnt + 1'b1;
                // A done arriving on the timeout cycle still returns the product.
                if (mul_done) begin
                    res_data_nxt = mul_product;
                    res_err_nxt  = 1'b0;
                    state_nxt    = OUT;
                end else if (timed_out) begin
                    res_data_nxt = '0;
                    res_err_nxt  = 1'b1;
                    state_nxt    = OUT;
                end
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Self-checking bench: one sequencer with zero bypass, one without, sharing a
// behavioural multiplier whose done delay is set per operation.
module tb_mul_operand_sequencer;

    localparam int W        = 16;
    localparam int TO       = 20;
    localparam int TO_CYCLE = 4 + TO - 1;   // last WAIT cycle, counted from the accept edge
    localparam int NEVER    = 1000000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          delay;     // done high this many cycles after mul_start; 0 = never
        int          bp;        // cycles res_ready stays low once res_valid is expected
        int          spur;      // cycle in which a spurious done is pulsed; 0 = none
        bit          poke;      // offer a new operand pair while the result is pending
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         op_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic         spur_done = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         mul_done;
    logic [W-1:0] mul_product;

    logic         d_op_ready, d_mul_start, d_res_valid, d_res_err, d_busy;
    logic [W-1:0] d_mul_data, d_res_data;
    logic         n_op_ready, n_mul_start, n_res_valid, n_res_err, n_busy;
    logic [W-1:0] n_mul_data, n_res_data;

    int n_checks = 0;
    int n_fail   = 0;
    int mk_delay = 0;

    vec_t table_v[9];

    always #5 clk = ~clk;

    mul_operand_sequencer #(.W(W), .TIMEOUT(TO), .CNT_W(17), .BYPASS_ZERO(1'b1)) u_dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(d_op_ready),
        .op_a(op_a), .op_b(op_b), .mul_start(d_mul_start), .mul_data(d_mul_data),
        .mul_done(mul_done), .mul_product(mul_product), .res_valid(d_res_valid),
        .res_ready(res_ready), .res_data(d_res_data), .res_err(d_res_err), .busy(d_busy)
    );

    mul_operand_sequencer #(.W(W), .TIMEOUT(TO), .CNT_W(17), .BYPASS_ZERO(1'b0)) u_nb (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(n_op_ready),
        .op_a(op_a), .op_b(op_b), .mul_start(n_mul_start), .mul_data(n_mul_data),
        .mul_done(mul_done), .mul_product(mul_product), .res_valid(n_res_valid),
        .res_ready(res_ready), .res_data(n_res_data), .res_err(n_res_err), .busy(n_busy)
    );

    // Behavioural multiplier: captures A and B from the bus in the two cycles after
    // start and raises done mk_delay cycles after start. The product is only
    // meaningful while done is high, mimicking an accumulator still in motion.
    logic         mk_active, mk_done;
    int           mk_t;
    logic [W-1:0] mk_a, mk_b, mk_prod, bus;

    assign bus         = d_mul_data | n_mul_data;
    assign mk_prod     = mk_a * mk_b;
    assign mul_product = mk_done ? mk_prod : 16'hBEEF;
    assign mul_done    = mk_done | spur_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mk_active <= 1'b0;
            mk_t      <= 0;
            mk_a      <= '0;
            mk_b      <= '0;
            mk_done   <= 1'b0;
        end else if (d_mul_start || n_mul_start) begin
            mk_active <= 1'b1;
            mk_t      <= 1;
            mk_done   <= 1'b0;
        end else if (mk_active) begin
            if (mk_t == 1) mk_a <= bus;
            if (mk_t == 2) mk_b <= bus;
            mk_done <= (mk_delay != 0) && (mk_t + 1 == mk_delay);
            if (mk_done) mk_active <= 1'b0;
            mk_t <= mk_t + 1;
        end
    end

    task automatic check_output(input string name, input int c,
                                input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s (cycle %0d): got %0d, expected %0d", name, c, act, exp);
        end
    endtask

    // Reference model: result value, error flag and the cycle res_valid first rises.
    task automatic model(input logic [15:0] a, input logic [15:0] b, input int delay,
                         input bit byp, output logic [15:0] data, output logic err,
                         output int res_c);
        int done_c;
        done_c = (delay == 0) ? NEVER : 1 + delay;
        if (byp && (a == 0 || b == 0)) begin
            data = 16'd0; err = 1'b0; res_c = 1;
        end else if (done_c > TO_CYCLE) begin
            data = 16'd0; err = 1'b1; res_c = TO_CYCLE + 1;
        end else begin
            data = 16'((32'(a) * 32'(b)) % 32'd65536); err = 1'b0; res_c = done_c + 1;
        end
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!(d_op_ready && n_op_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_output("ready_wait_bound", k, 32'(k < 100), 32'd1);
    endtask

    task automatic apply_stimulus(input vec_t v);
        logic [15:0] dd, nd;
        logic        de, ne;
        int          dres, nres, rr, dend, nend, last;
        bit          dbyp;
        logic [15:0] exp_bus;
        model(v.a, v.b, v.delay, 1'b1, dd, de, dres);
        model(v.a, v.b, v.delay, 1'b0, nd, ne, nres);
        dbyp = (dres == 1);
        rr   = dres + v.bp;
        dend = rr;
        nend = (nres > rr) ? nres : rr;
        last = ((dend > nend) ? dend : nend) + 2;
        res_ready = 1'b0;
        spur_done = 1'b0;
        wait_ready();
        op_a     = v.a;
        op_b     = v.b;
        mk_delay = v.delay;
        op_valid = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_bus = (!dbyp && c == 2) ? v.a : ((!dbyp && c == 3) ? v.b : 16'd0);
            check_output("mul_start", c, 32'(d_mul_start), 32'(!dbyp && c == 1));
            check_output("mul_data", c, 32'(d_mul_data), 32'(exp_bus));
            check_output("res_valid", c, 32'(d_res_valid), 32'(c >= dres && c <= dend));
            if (c >= dres && c <= dend) begin
                check_output("res_data", c, 32'(d_res_data), 32'(v.exp_data));
                check_output("res_err", c, 32'(d_res_err), 32'(v.exp_err));
            end
            check_output("busy", c, 32'(d_busy), 32'(c <= dend));
            check_output("op_ready", c, 32'(d_op_ready), 32'(c > dend));
            check_output("nb_res_valid", c, 32'(n_res_valid), 32'(c >= nres && c <= nend));
            if (c >= nres && c <= nend) begin
                check_output("nb_res_data", c, 32'(n_res_data), 32'(nd));
                check_output("nb_res_err", c, 32'(n_res_err), 32'(ne));
            end
            op_valid  = v.poke && (c >= dres) && (c < rr);
            res_ready = (c >= rr);
            spur_done = (c == v.spur);
        end
        res_ready = 1'b0;
        op_valid  = 1'b0;
        spur_done = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t rv;
        logic [15:0] md;
        logic        me;
        int          mc;

        //            a       b       dly bp spur poke exp_data exp_err
        table_v[0] = '{16'd17,    16'd5,     8,  0, 0, 1'b0, 16'd85,    1'b0};
        table_v[1] = '{16'd0,     16'd9,     8,  0, 0, 1'b0, 16'd0,     1'b0};
        table_v[2] = '{16'd9,     16'd0,     8,  0, 0, 1'b0, 16'd0,     1'b0};
        table_v[3] = '{16'd3,     16'd4,     5,  10, 0, 1'b1, 16'd12,   1'b0};
        table_v[4] = '{16'd100,   16'd200,   0,  0, 0, 1'b0, 16'd0,     1'b1};
        table_v[5] = '{16'd300,   16'd300,   22, 0, 0, 1'b0, 16'd24464, 1'b0};
        table_v[6] = '{16'd65535, 16'd65535, 21, 2, 0, 1'b0, 16'd1,     1'b0};
        table_v[7] = '{16'd5,     16'd5,     3,  0, 0, 1'b0, 16'd25,    1'b0};
        table_v[8] = '{16'd6,     16'd7,     8,  1, 2, 1'b0, 16'd42,    1'b0};

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        check_output("rst_op_ready", 0, 32'(d_op_ready), 32'd0);
        check_output("rst_mul_start", 0, 32'(d_mul_start), 32'd0);
        check_output("rst_mul_data", 0, 32'(d_mul_data), 32'd0);
        check_output("rst_res_valid", 0, 32'(d_res_valid), 32'd0);
        check_output("rst_res_data", 0, 32'(d_res_data), 32'd0);
        check_output("rst_res_err", 0, 32'(d_res_err), 32'd0);
        check_output("rst_busy", 0, 32'(d_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_op_ready", 0, 32'(d_op_ready), 32'd1);

        // Spurious done while idle must be ignored.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        check_output("spur_idle_busy", 0, 32'(d_busy), 32'd0);
        check_output("spur_idle_res_valid", 0, 32'(d_res_valid), 32'd0);
        check_output("spur_idle_nb_busy", 0, 32'(n_busy), 32'd0);
        @(negedge clk);

        $display("[TB] directed table");
        for (int i = 0; i < 9; i++) apply_stimulus(table_v[i]);

        // Reset in cycle 6 (inside WAIT) discards the operation immediately.
        $display("[TB] reset mid-WAIT");
        wait_ready();
        op_a = 16'd7; op_b = 16'd7; mk_delay = 8; op_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        @(posedge clk);
        #2;
        check_output("pre_rst_busy", 6, 32'(d_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_output("mid_rst_busy", 6, 32'(d_busy), 32'd0);
        check_output("mid_rst_op_ready", 6, 32'(d_op_ready), 32'd0);
        check_output("mid_rst_mul_data", 6, 32'(d_mul_data), 32'd0);
        check_output("mid_rst_res_valid", 6, 32'(d_res_valid), 32'd0);
        check_output("mid_rst_res_data", 6, 32'(d_res_data), 32'd0);
        check_output("mid_rst_res_err", 6, 32'(d_res_err), 32'd0);
        check_output("mid_rst_nb_busy", 6, 32'(n_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rv = '{16'd2, 16'd3, 8, 0, 0, 1'b0, 16'd6, 1'b0};
        apply_stimulus(rv);

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            rv.a     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            rv.b     = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            rv.delay = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(3, 22));
            rv.bp    = int'($urandom_range(0, 3));
            rv.spur  = 0;
            rv.poke  = 1'b0;
            model(rv.a, rv.b, rv.delay, 1'b1, md, me, mc);
            rv.exp_data = md;
            rv.exp_err  = me;
            apply_stimulus(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_operand_sequencer.md
# mul_operand_sequencer

Upstream front-end for the repeated-addition multiplier (datapath + controlpath pair). It accepts an operand pair over a valid/ready handshake and pulses `mul_start`. It then serialises A and B onto the multiplier's single 16-bit `data_in` bus in the exact load cycles, waits for `done`, and returns the captured product over a valid/ready result handshake. It also short-circuits zero operands and flags a multiplier that never finishes.

## Interface

Parameters:
- `W`, 16, operand/product width; equals multiplier `data_in` width
- `TIMEOUT`, 70000, max cycles in WAIT before error (covers B=65535 worst case)
- `CNT_W`, 17, timeout counter width; must hold TIMEOUT
- `BYPASS_ZERO`, 1, 1 = A==0 or B==0 returns 0 without running the multiplier

Ports:
- `clk`  in  1  rising-edge clock, shared with multiplier
- `rst`  in  1  asynchronous, active-high reset
- `op_valid`  in  1  operand pair valid
- `op_ready`  out  1  sequencer can accept operands
- `op_a`  in  W  multiplicand
- `op_b`  in  W  multiplier (loop count)
- `mul_start`  out  1  to multiplier `start`
- `mul_data`  out  W  to multiplier `data_in`
- `mul_done`  in  1  from multiplier `done`
- `mul_product`  in  W  from multiplier product register
- `res_valid`  out  1  result valid
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  W  product (low W bits), 0 on error
- `res_err`  out  1  qualifies `res_data`: 1 = timeout
- `busy`  out  1  high in any state except IDLE

## Operation

- Reset values (async, immediate): state IDLE, `op_ready`=0 while `rst` high then 1 in IDLE, `mul_start`=0, `mul_data`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `busy`=0, counter 0, operand registers 0.
- States: IDLE, START, LOAD_A, LOAD_B, WAIT, OUT.
- IDLE: `op_ready`=1. On `op_valid & op_ready`, latch `op_a`/`op_b`.
  - If BYPASS_ZERO and a latched operand is 0 → OUT with `res_data`=0, `res_err`=0.
  - Else → START.
- START: `mul_start`=1 (one cycle), `mul_data`=0 → LOAD_A.
- LOAD_A: `mul_data`=A (controller `ld_a` cycle) → LOAD_B.
- LOAD_B: `mul_data`=B (controller `ld_b` cycle) → WAIT. Clear counter.
- WAIT: `mul_data`=0. Counter increments each cycle.
  - `mul_done` sampled high → capture `mul_product` into `res_data`, `res_err`=0 → OUT.
  - Counter reaches TIMEOUT-1 without done → `res_data`=0, `res_err`=1 → OUT.
  - Done and timeout in the same cycle: done wins.
- OUT: `res_valid`=1; `res_data`/`res_err` held stable until `res_valid & res_ready` → IDLE. `op_ready`=0 throughout.
- `mul_done` outside WAIT is ignored. `mul_data`=0 in every state except LOAD_A/LOAD_B.
- Product is truncated to W bits, matching the multiplier; no overflow flag.
- No internal buffering: one operation in flight.

## Timing

- Accept edge = cycle 0. `mul_start` high in cycle 1, A on bus in cycle 2, B on bus in cycle 3. WAIT from cycle 4.
- `res_valid` rises the cycle after the edge where `mul_done` is sampled high.
- Bypass: `res_valid` in cycle 1. Minimum accept-to-accept: 2 cycles if `res_ready` is held high.
- `res_ready` high in the first OUT cycle: `op_ready` is high again in the next cycle.
- `rst` mid-operation: all outputs return to reset values immediately; latched operands and the result are discarded. The multiplier must share `rst` or be re-started.

## Test plan

- Nominal: A=17, B=5, model multiplier asserts done 8 cycles after start with product 85 -> `mul_start` cycle 1, `mul_data`=17 cycle 2, =5 cycle 3, `res_data`=85, `res_err`=0.
- Zero bypass: A=0, B=9 and A=9, B=0 -> `mul_start` never asserted, `res_valid` in cycle 1, `res_data`=0. With BYPASS_ZERO=0 the multiplier runs normally.
- Back-pressure: A=3, B=4, `res_ready` held low 10 cycles -> `res_valid`=1 and `res_data`=12 stable throughout, `op_ready`=0, a new `op_valid` is not accepted.
- Timeout: TIMEOUT=20, done never asserted -> `res_valid` with `res_err`=1, `res_data`=0. Also: done and timeout in the same cycle -> `res_err`=0, product returned.
- Reset mid-WAIT: assert `rst` in cycle 6 of A=7, B=7 -> all outputs 0 immediately, `busy`=0, next op A=2, B=3 returns 6.
- Spurious done: `mul_done` pulsed in IDLE and in LOAD_A -> no state change, no result.
